nav_cmd_sched: RTL and testbench
================================

# nav_cmd_sched

Command scheduler that sits between the command front end and `navigate`. Buffers 16-bit movement commands in a small FIFO, decodes them, and issues one `strt_hdng`/`strt_mv` at a time to `navigate`. Each command runs to `mv_cmplt` before the next is dispatched, and a one-byte response is returned per command.

## Interface
Parameters:
- `QDEPTH`, 4: command FIFO depth. Power of two, 2..16.
- `WDOG_CYCLES`, 24'hFF_FFFF: watchdog limit in clk cycles. Used only with `NAV_WATCHDOG_EN`.

Ports:
- `clk`  in  1  system clock. Only clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `cmd`  in  16  command word: opcode `[15:13]`, payload `[11:0]`.
- `cmd_vld`  in  1  command offered.
- `cmd_rdy`  out  1  FIFO not full. Push occurs when `cmd_vld & cmd_rdy`.
- `mv_cmplt`  in  1  completion pulse from `navigate`.
- `strt_hdng`  out  1  one-cycle pulse to `navigate`.
- `strt_mv`  out  1  one-cycle pulse to `navigate`.
- `dsrd_hdng`  out  12  desired heading. Held between HDNG commands.
- `stp_lft`  out  1  stop at left opening. Held between MOVE commands.
- `stp_rght`  out  1  stop at right opening. Held between MOVE commands.
- `resp`  out  8  response code. Valid with `resp_vld`.
- `resp_vld`  out  1  one-cycle response pulse.
- `busy`  out  1  high in any state except IDLE.
- `q_cnt`  out  5  FIFO occupancy, 0..QDEPTH.

## Operation
Opcodes:
- 3'b000 NOP: no `navigate` activity. Responds `RESP_ACK` (8'hA5).
- 3'b001 HDNG: `dsrd_hdng <= cmd[11:0]`, then pulse `strt_hdng`.
- 3'b010 MOVE: `stp_lft <= cmd[1]`, `stp_rght <= cmd[0]`, then pulse `strt_mv`.
- Any other opcode: no `navigate` activity. Responds `RESP_ERR` (8'hEE).

State machine:
- IDLE: if `q_cnt != 0`, pop the FIFO head into the command register and go to ISSUE. Otherwise stay.
- ISSUE: for HDNG/MOVE, drive the start pulse and update the held outputs on the same edge, then go to WAIT. For NOP/illegal, go to RESP.
- WAIT: on `mv_cmplt`, go to RESP with `RESP_ACK`. Otherwise stay.
- RESP: `resp_vld` is 1 for exactly one cycle, then go to IDLE.

General rules:
- `mv_cmplt` is ignored outside WAIT.
- FIFO push and pop in the same cycle are both honored and `q_cnt` is unchanged.
- `cmd_rdy` is derived from the registered count only. There is no same-cycle bypass when the FIFO is full.
- A push while full is impossible by the handshake; `cmd_vld` while `!cmd_rdy` is ignored.
- FIFO pointers wrap modulo QDEPTH. `q_cnt` is one bit wider than the pointers.

Reset values (`rst` high on a `clk` edge):
- state = IDLE, FIFO empty.
- `q_cnt = 0`, `cmd_rdy = 1`.
- `strt_hdng = strt_mv = 0`, `dsrd_hdng = 12'h000`, `stp_lft = stp_rght = 0`.
- `resp = 8'h00`, `resp_vld = 0`, `busy = 0`.
- Reset mid-command abandons the command with no response. The FIFO contents are discarded.

## Timing
- All outputs are registered.
- Push at edge N makes the entry visible at N+1. IDLE pops at edge N+1, ISSUE pulses the start at edge N+2. The start is high during cycle N+2..N+3.
- `dsrd_hdng`/`stp_*` change on the same edge that raises `strt_*`.
- `mv_cmplt` sampled at edge M produces `resp_vld` high in the cycle after edge M+1.
- NOP/illegal: `resp_vld` is asserted 3 cycles after the push edge.
- Back-to-back commands have a minimum gap of 1 IDLE cycle between `resp_vld` and the next start pulse.

## Configuration
- `NAV_WATCHDOG_EN` defined:
  - A 24-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching `WDOG_CYCLES` without `mv_cmplt` sends `RESP_TMO` (8'h5A), flushes the FIFO (`q_cnt` becomes 0), and goes through RESP to IDLE.
  - `mv_cmplt` in the same cycle as expiry wins, giving `RESP_ACK` with no flush.
- Not defined: no counter. WAIT persists until `mv_cmplt`, and `RESP_TMO` is never produced.

## Structure
- Package `nav_pkg` holds:
  - `opcode_t` enum: OP_NOP, OP_HDNG, OP_MOVE.
  - `sched_state_t` enum: IDLE, ISSUE, WAIT, RESP.
  - Localparams `RESP_ACK`, `RESP_ERR`, `RESP_TMO`.
- One sub-module, `cmd_fifo`: parameterised depth, push/pop/flush, count output, synchronous active-high `rst`.
- Decode, FSM, held registers and watchdog live in `nav_cmd_sched`.

## Test plan
- Push 16'h2123 (HDNG 12'h123) into an idle block → `strt_hdng` single pulse 2 cycles after the push, with `dsrd_hdng = 12'h123` in the same cycle. Drive `mv_cmplt` 50 cycles later → `resp = 8'hA5` with a one-cycle `resp_vld` 2 cycles later.
- Push 16'h4002 (MOVE, left) → `strt_mv` pulse with `stp_lft = 1`, `stp_rght = 0`. A `mv_cmplt` pulsed during ISSUE is ignored. A `mv_cmplt` in WAIT → `RESP_ACK`.
- Push QDEPTH+1 = 5 commands back-to-back while WAIT is stalled → `cmd_rdy` drops after the 4th, the 5th is held, and `q_cnt = 4`. Complete each → 4 in-order starts and responses, then the 5th is accepted.
- Push 16'hE000 and 16'h0000 → `resp` 8'hEE then 8'hA5, with no start pulses and no change to `dsrd_hdng` or `stp_*`.
- With `NAV_WATCHDOG_EN`, `WDOG_CYCLES = 100`, a HDNG followed by 2 queued commands, and no `mv_cmplt` → `resp = 8'h5A` after 100 WAIT cycles, `q_cnt = 0`, and no further starts.
- Assert `rst` during WAIT with 2 queued commands → next cycle all outputs are at reset values and `q_cnt = 0`. A later `mv_cmplt` produces no response.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation command scheduler.
package nav_pkg;

  // Command opcodes carried in cmd[15:13]; other encodings are illegal.
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_HDNG = 3'b001,
    OP_MOVE = 3'b010
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;
  localparam logic [7:0] RESP_TMO = 8'h5A;

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO: power-of-two depth, registered count, synchronous flush.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally since DEPTH is a power of two; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/nav_cmd_sched.sv
// Command scheduler in front of navigate: queues commands, issues one start at a
// time and returns one response byte per command.
// Optional watchdog on the WAIT state is enabled by defining NAV_WATCHDOG_EN.
module nav_cmd_sched
  import nav_pkg::*;
#(
  parameter int unsigned QDEPTH      = 4,
  parameter logic [23:0] WDOG_CYCLES = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic        mv_cmplt,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic [11:0] dsrd_hdng,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        busy,
  output logic [4:0]  q_cnt
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  sched_state_t state_q, state_d;
  logic [15:0]  cmd_q, cmd_d;
  logic [11:0]  hdng_q, hdng_d;
  logic         lft_q, lft_d, rght_q, rght_d;
  logic         strt_hdng_q, strt_hdng_d, strt_mv_q, strt_mv_d;
  logic [7:0]   resp_q, resp_d;
  logic         resp_vld_q, resp_vld_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [15:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  assign cmd_rdy   = ~fifo_full;
  assign fifo_push = cmd_vld & cmd_rdy;

  cmd_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (cmd),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef NAV_WATCHDOG_EN
  logic [23:0] wdog_q, wdog_d;

  // Watchdog counter; held at zero outside WAIT so it is clear on entry.
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^{WDOG_CYCLES, RESP_TMO};
`endif

  // cmd[12] is reserved in every opcode.
  logic unused_cmd_bit;
  assign unused_cmd_bit = cmd_q[12];

  // Next-state decode; start pulses and held outputs change on the same edge.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hdng_d      = hdng_q;
    lft_d       = lft_q;
    rght_d      = rght_q;
    strt_hdng_d = 1'b0;
    strt_mv_d   = 1'b0;
    resp_d      = resp_q;
    resp_vld_d  = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
`ifdef NAV_WATCHDOG_EN
    wdog_d      = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        case (cmd_q[15:13])
          OP_HDNG: begin
            hdng_d      = cmd_q[11:0];
            strt_hdng_d = 1'b1;
            state_d     = WAIT;
          end
          OP_MOVE: begin
            lft_d     = cmd_q[1];
            rght_d    = cmd_q[0];
            strt_mv_d = 1'b1;
            state_d   = WAIT;
          end
          OP_NOP: begin
            resp_d  = RESP_ACK;
            state_d = RESP;
          end
          default: begin
            resp_d  = RESP_ERR;
            state_d = RESP;
          end
        endcase
      end
      WAIT: begin
        // Completion beats a same-cycle watchdog expiry.
        if (mv_cmplt) begin
          resp_d  = RESP_ACK;
          state_d = RESP;
        end
`ifdef NAV_WATCHDOG_EN
        else if (wdog_q == WDOG_CYCLES - 24'd1) begin
          resp_d     = RESP_TMO;
          fifo_flush = 1'b1;
          state_d    = RESP;
        end else begin
          wdog_d = wdog_q + 24'd1;
        end
`endif
      end
      RESP: begin
        resp_vld_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state, command register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      hdng_q      <= '0;
      lft_q       <= 1'b0;
      rght_q      <= 1'b0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      resp_q      <= '0;
      resp_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      hdng_q      <= hdng_d;
      lft_q       <= lft_d;
      rght_q      <= rght_d;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      resp_q      <= resp_d;
      resp_vld_q  <= resp_vld_d;
    end
  end

  assign strt_hdng = strt_hdng_q;
  assign strt_mv   = strt_mv_q;
  assign dsrd_hdng = hdng_q;
  assign stp_lft   = lft_q;
  assign stp_rght  = rght_q;
  assign resp      = resp_q;
  assign resp_vld  = resp_vld_q;
  assign busy      = (state_q != IDLE);
  assign q_cnt     = 5'(fifo_count);

endmodule

// File: tb/tb_nav_cmd_sched.sv
// Self-checking bench for nav_cmd_sched: directed vector table, hand sequences
// for multi-cycle corners, and random traffic against a transaction-level model.
module tb_nav_cmd_sched;

  localparam int unsigned QDEPTH = 4;
  localparam int          WDOG   = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        mv_cmplt;
  logic        strt_hdng, strt_mv;
  logic [11:0] dsrd_hdng;
  logic        stp_lft, stp_rght;
  logic [7:0]  resp;
  logic        resp_vld, busy;
  logic [4:0]  q_cnt;

  nav_cmd_sched #(
    .QDEPTH      (QDEPTH),
    .WDOG_CYCLES (24'd100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .mv_cmplt  (mv_cmplt),
    .strt_hdng (strt_hdng),
    .strt_mv   (strt_mv),
    .dsrd_hdng (dsrd_hdng),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .resp      (resp),
    .resp_vld  (resp_vld),
    .busy      (busy),
    .q_cnt     (q_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: commands waiting to be offered, and accepted commands in order.
  logic [15:0] pushq [$];
  logic [15:0] expq  [$];
  logic        in_wait = 1'b0, started = 1'b0, due_now = 1'b0, tmo_pend = 1'b0;
  int          resp_due = 0;
  logic [11:0] m_hdng = 12'h000;
  logic        m_lft = 1'b0, m_rght = 1'b0;
`ifdef NAV_WATCHDOG_EN
  int          wcnt = 0;
`endif

  typedef struct packed {
    logic [15:0] cmd;
    logic        sh;
    logic        sm;
    logic [11:0] hdng;
    logic        lft;
    logic        rght;
    logic [7:0]  resp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [2:0]  op;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 4)       op = 3'd1;
    else if (r < 7)  op = 3'd2;
    else if (r == 7) op = 3'd0;
    else             op = 3'($urandom_range(3, 7));
    return {op, 13'($urandom)};
  endfunction

  task automatic model_reset();
    expq.delete();
    in_wait  = 1'b0;
    started  = 1'b0;
    due_now  = 1'b0;
    tmo_pend = 1'b0;
    resp_due = 0;
    m_hdng   = 12'h000;
    m_lft    = 1'b0;
    m_rght   = 1'b0;
  endtask

  // Compare observed start/response events and held outputs with the model.
  task automatic monitor();
    logic [2:0] op;
    logic       motion;
    if (strt_hdng || strt_mv) begin
      if (expq.size() == 0 || started) begin
        chk("extra_start", {30'd0, strt_hdng, strt_mv}, 32'd0);
      end else begin
        op = expq[0][15:13];
        chk("start_kind", {30'd0, strt_hdng, strt_mv},
            (op == 3'd1) ? 32'd2 : (op == 3'd2) ? 32'd1 : 32'd0);
        if (op == 3'd1) m_hdng = expq[0][11:0];
        else if (op == 3'd2) begin
          m_lft  = expq[0][1];
          m_rght = expq[0][0];
        end
        started = 1'b1;
        in_wait = 1'b1;
`ifdef NAV_WATCHDOG_EN
        wcnt = 0;
`endif
      end
    end
    if (due_now) chk("resp_latency", resp_vld, 1'b1);
    if (resp_vld) begin
      if (expq.size() == 0) begin
        chk("spurious_resp", resp_vld, 1'b0);
      end else begin
        op     = expq[0][15:13];
        motion = (op == 3'd1) || (op == 3'd2);
        if (motion && !due_now) begin
          chk("early_resp", resp_vld, 1'b0);
        end else begin
          chk("resp_code", resp,
              motion ? (tmo_pend ? 8'h5A : 8'hA5) : ((op == 3'd0) ? 8'hA5 : 8'hEE));
          void'(expq.pop_front());
          started  = 1'b0;
          tmo_pend = 1'b0;
        end
      end
    end else if (due_now && expq.size() != 0) begin
      void'(expq.pop_front());
      started  = 1'b0;
      tmo_pend = 1'b0;
    end
    due_now = 1'b0;
    chk("held_hdng", dsrd_hdng, m_hdng);
    chk("held_lft", stp_lft, m_lft);
    chk("held_rght", stp_rght, m_rght);
    chk("rdy_vs_cnt", cmd_rdy, (q_cnt < 5'(QDEPTH)));
  endtask

  // One clock: offer the next queued command, advance the model, sample #1 after the edge.
  task automatic tick();
    logic took, mvc, tmo;
    cmd_vld = (pushq.size() != 0);
    if (cmd_vld) cmd = pushq[0];
    else         cmd = 16'h0000;
    took = cmd_vld && cmd_rdy && !rst;
    mvc  = mv_cmplt && in_wait && !rst;
    tmo  = 1'b0;
`ifdef NAV_WATCHDOG_EN
    if (in_wait && !mvc && !rst) begin
      wcnt++;
      if (wcnt == WDOG) tmo = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    mv_cmplt = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (took) expq.push_back(pushq.pop_front());
      if (mvc || tmo) begin
        in_wait  = 1'b0;
        resp_due = 2;
        tmo_pend = tmo;
      end
      if (tmo) while (expq.size() > 1) void'(expq.pop_back());
      if (resp_due > 0) begin
        resp_due--;
        if (resp_due == 0) due_now = 1'b1;
      end
    end
    monitor();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_strt_hdng"}, strt_hdng, 1'b0);
    chk({tag, "_strt_mv"}, strt_mv, 1'b0);
    chk({tag, "_dsrd_hdng"}, dsrd_hdng, 12'h000);
    chk({tag, "_stp_lft"}, stp_lft, 1'b0);
    chk({tag, "_stp_rght"}, stp_rght, 1'b0);
    chk({tag, "_resp"}, resp, 8'h00);
    chk({tag, "_resp_vld"}, resp_vld, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_q_cnt"}, q_cnt, 5'd0);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
  endtask

  task automatic wait_start(input string name);
    int t = 0;
    while (!(strt_hdng || strt_mv) && t < 40) begin
      tick();
      t++;
    end
    chk(name, strt_hdng || strt_mv, 1'b1);
  endtask

  task automatic complete(input string name, input logic [7:0] exp_resp);
    int t = 0;
    mv_cmplt = 1'b1;
    tick();
    while (!resp_vld && t < 10) begin
      tick();
      t++;
    end
    chk({name, "_vld"}, resp_vld, 1'b1);
    chk({name, "_code"}, resp, exp_resp);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] fifo_exp [6];
    logic        seen;
    int          t;

    vecs[0]  = '{16'h2123, 1'b1, 1'b0, 12'h123, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{16'h4002, 1'b0, 1'b1, 12'h123, 1'b1, 1'b0, 8'hA5};
    vecs[2]  = '{16'hE000, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 8'hEE};
    vecs[3]  = '{16'h0000, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{16'h4001, 1'b0, 1'b1, 12'h123, 1'b0, 1'b1, 8'hA5};
    vecs[5]  = '{16'h3FFF, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b1, 8'hA5};
    vecs[6]  = '{16'h6ABC, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 8'hEE};
    vecs[7]  = '{16'h5FFF, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b1, 8'hA5};
    vecs[8]  = '{16'h8123, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b1, 8'hEE};
    vecs[9]  = '{16'h2000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 8'hA5};
    vecs[10] = '{16'hA000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 8'hEE};
    vecs[11] = '{16'hC000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 8'hEE};
    vecs[12] = '{16'h1FFF, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 8'hA5};

    rst = 1'b1;
    cmd = 16'h0000;
    cmd_vld = 1'b0;
    mv_cmplt = 1'b0;
    tick();
    tick();
    check_reset_vals("init");
    rst = 1'b0;

    // Single commands into an idle block with exact cycle timing.
    foreach (vecs[i]) begin
      pushq.push_back(vecs[i].cmd);
      tick();
      chk("vec_qcnt_after_push", q_cnt, 5'd1);
      tick();
      chk("vec_busy_issue", busy, 1'b1);
      chk("vec_no_early_start", strt_hdng | strt_mv, 1'b0);
      tick();
      chk("vec_strt_hdng", strt_hdng, vecs[i].sh);
      chk("vec_strt_mv", strt_mv, vecs[i].sm);
      chk("vec_dsrd_hdng", dsrd_hdng, vecs[i].hdng);
      chk("vec_stp_lft", stp_lft, vecs[i].lft);
      chk("vec_stp_rght", stp_rght, vecs[i].rght);
      if (vecs[i].sh || vecs[i].sm) begin
        tick();
        chk("vec_start_single", strt_hdng | strt_mv, 1'b0);
        repeat (49) tick();
        mv_cmplt = 1'b1;
        tick();
        chk("vec_resp_not_yet", resp_vld, 1'b0);
        tick();
      end else begin
        tick();
      end
      chk("vec_resp_vld", resp_vld, 1'b1);
      chk("vec_resp", resp, vecs[i].resp);
      chk("vec_hdng_kept", dsrd_hdng, vecs[i].hdng);
      tick();
      chk("vec_resp_single", resp_vld, 1'b0);
      chk("vec_idle", busy, 1'b0);
    end

    // mv_cmplt during ISSUE is ignored; the later one in WAIT completes the move.
    pushq.push_back(16'h4002);
    tick();
    tick();
    mv_cmplt = 1'b1;
    tick();
    chk("issue_cmplt_strt_mv", strt_mv, 1'b1);
    chk("issue_cmplt_lft", stp_lft, 1'b1);
    chk("issue_cmplt_rght", stp_rght, 1'b0);
    repeat (4) begin
      tick();
      chk("issue_cmplt_no_resp", resp_vld, 1'b0);
      chk("issue_cmplt_busy", busy, 1'b1);
    end
    complete("issue_cmplt_ack", 8'hA5);

    // mv_cmplt while idle does nothing.
    mv_cmplt = 1'b1;
    repeat (3) tick();
    chk("idle_cmplt_no_resp", resp_vld, 1'b0);
    chk("idle_cmplt_idle", busy, 1'b0);

    // Fill the FIFO behind a stalled HDNG; the fifth push waits for space.
    fifo_exp = '{12'h100, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
    pushq.push_back(16'h2100);
    tick();
    tick();
    tick();
    chk("fifo_first_start", strt_hdng, 1'b1);
    for (int k = 1; k <= 5; k++) pushq.push_back({4'h2, 12'(k)});
    repeat (4) tick();
    chk("fifo_full_qcnt", q_cnt, 5'd4);
    chk("fifo_full_rdy", cmd_rdy, 1'b0);
    repeat (3) tick();
    chk("fifo_held_qcnt", q_cnt, 5'd4);
    chk("fifo_fifth_held", pushq.size(), 1);
    complete("fifo_resp0", 8'hA5);
    for (int k = 1; k <= 5; k++) begin
      wait_start("fifo_start");
      chk("fifo_order", dsrd_hdng, fifo_exp[k]);
      complete("fifo_resp", 8'hA5);
    end
    chk("fifo_fifth_taken", pushq.size(), 0);
    chk("fifo_drained", q_cnt, 5'd0);

    // Reset while waiting with two commands queued.
    pushq.push_back(16'h2ABC);
    pushq.push_back(16'h4003);
    pushq.push_back(16'h0000);
    tick();
    tick();
    tick();
    chk("rstwait_start", strt_hdng, 1'b1);
    chk("rstwait_qcnt", q_cnt, 5'd2);
    tick();
    chk("rstwait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("rstwait");
    mv_cmplt = 1'b1;
    tick();
    repeat (5) begin
      tick();
      chk("rstwait_no_resp", resp_vld, 1'b0);
    end
    chk("rstwait_idle", busy, 1'b0);

`ifdef NAV_WATCHDOG_EN
    // Watchdog expiry with two queued commands: timeout response and flush.
    pushq.push_back(16'h2111);
    pushq.push_back(16'h4001);
    pushq.push_back(16'h0000);
    tick();
    tick();
    tick();
    chk("wdog_start", strt_hdng, 1'b1);
    t = 0;
    while (!resp_vld && t < 200) begin
      tick();
      t++;
    end
    chk("wdog_latency", t, 101);
    chk("wdog_resp", resp, 8'h5A);
    chk("wdog_flush", q_cnt, 5'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | strt_hdng | strt_mv;
    end
    chk("wdog_no_start", seen, 1'b0);
    chk("wdog_idle", busy, 1'b0);
`endif

    // Random traffic against the transaction model.
    for (int c = 0; c < 3000; c++) begin
      if (pushq.size() < 2 && $urandom_range(0, 3) == 0) pushq.push_back(rand_cmd());
      mv_cmplt = ($urandom_range(0, 7) == 0);
      tick();
    end
    t = 0;
    while ((expq.size() != 0 || pushq.size() != 0 || busy) && t < 3000) begin
      mv_cmplt = ($urandom_range(0, 3) == 0);
      tick();
      t++;
    end
    chk("drain_empty", expq.size() + pushq.size(), 0);
    chk("drain_idle", busy, 1'b0);
    chk("drain_qcnt", q_cnt, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
